// File: rtl/alsu_pkg.sv
// Shared ALSU definitions: opcodes, flag bit positions, packed command and the
// invalid-operation rule used by both the command issuer and ALSU-side checkers.
package alsu_pkg;

    localparam logic [2:0] OP_OR    = 3'd0;
    localparam logic [2:0] OP_XOR   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_ROT   = 3'd5;

    // Bit positions inside the 7-bit flags field
    localparam int F_CIN       = 6;
    localparam int F_SERIAL_IN = 5;
    localparam int F_RED_OP_A  = 4;
    localparam int F_RED_OP_B  = 3;
    localparam int F_BYPASS_A  = 2;
    localparam int F_BYPASS_B  = 1;
    localparam int F_DIRECTION = 0;

    // Widest repeat field a command can carry; issuers use REP_W <= REP_MAX_W
    localparam int REP_MAX_W = 8;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [2:0]           a;
        logic [2:0]           b;
        logic [6:0]           flags;
        logic [REP_MAX_W-1:0] rep;
    } alsu_cmd_t;

    function automatic logic is_invalid(alsu_cmd_t cmd);
        logic red_any;
        red_any = cmd.flags[F_RED_OP_A] | cmd.flags[F_RED_OP_B];
        return (cmd.opcode[2] & cmd.opcode[1]) |
               (red_any & (cmd.opcode[2] | cmd.opcode[1]));
    endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Generic synchronous FIFO with occupancy count; pointers wrap naturally, so
// DEPTH must be a power of two. Push when full and pop when empty are ignored.
module alsu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & (count_q != FULL_CNT);
    assign do_pop  = pop & (count_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/alsu_cmd_issuer.sv
// ALSU command issuer: screens and queues packed operations, then drives the
// ALSU pins one command at a time, holding each for its repeat count.
//
//   state    | meaning
//   S_IDLE   | no command active, ALSU pins carry the all-zero NOP
//   S_ACTIVE | pins carry the loaded command, rem counts hold cycles left
module alsu_cmd_issuer
    import alsu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int REP_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_opcode,
    input  logic [2:0]             cmd_A,
    input  logic [2:0]             cmd_B,
    input  logic [6:0]             cmd_flags,
    input  logic [REP_W-1:0]       cmd_repeat,
    output logic [2:0]             A,
    output logic [2:0]             B,
    output logic [2:0]             opcode,
    output logic                   cin,
    output logic                   serial_in,
    output logic                   red_op_A,
    output logic                   red_op_B,
    output logic                   bypass_A,
    output logic                   bypass_B,
    output logic                   direction,
    output logic                   issue_valid,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             reject_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [REP_W-1:0] REM_ONE  = REP_W'(1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                  state_q, state_d;
    logic [REP_W-1:0]        rem_q, rem_d;
    logic [2:0]              op_q, op_d;
    logic [2:0]              a_q, a_d;
    logic [2:0]              b_q, b_d;
    logic [6:0]              flags_q, flags_d;
    logic [7:0]              reject_q;

    alsu_cmd_t               in_cmd;
    alsu_cmd_t               head;
    logic [$bits(alsu_cmd_t)-1:0] head_raw;
    logic [REP_MAX_W-1:0]    head_rep;
    logic                    xfer;
    logic                    drop;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;

    assign in_cmd = '{opcode: cmd_opcode, a: cmd_A, b: cmd_B,
                      flags: cmd_flags, rep: REP_MAX_W'(cmd_repeat)};

    assign cmd_ready  = (fifo_count != FULL_CNT);
    assign fifo_empty = (fifo_count == '0);
    assign xfer       = cmd_valid & cmd_ready;
    // Invalid ops are swallowed unless a bypass bit asks for the ALSU's own handling
    assign drop       = is_invalid(in_cmd) & ~in_cmd.flags[F_BYPASS_A] & ~in_cmd.flags[F_BYPASS_B];
    assign push       = xfer & ~drop;
    assign head       = alsu_cmd_t'(head_raw);

    alsu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(alsu_cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_cmd),
        .dout  (head_raw),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        flags_d  = flags_q;
        pop      = 1'b0;
        head_rep = (head.rep == '0) ? REP_MAX_W'(1) : head.rep;

        // Loading on the last hold cycle gives bubble-free back-to-back issue
        if (!fifo_empty && (state_q == S_IDLE || rem_q == REM_ONE)) begin
            pop     = 1'b1;
            state_d = S_ACTIVE;
            rem_d   = REP_W'(head_rep);
            op_d    = head.opcode;
            a_d     = head.a;
            b_d     = head.b;
            flags_d = head.flags;
        end else if (state_q == S_ACTIVE) begin
            if (rem_q == REM_ONE) begin
                state_d = S_IDLE;
                rem_d   = '0;
                op_d    = '0;
                a_d     = '0;
                b_d     = '0;
                flags_d = '0;
            end else begin
                rem_d = rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reject_q <= '0;
        end else if (xfer && drop && reject_q != 8'hFF) begin
            reject_q <= reject_q + 1'b1;
        end
    end

    assign opcode      = op_q;
    assign A           = a_q;
    assign B           = b_q;
    assign cin         = flags_q[F_CIN];
    assign serial_in   = flags_q[F_SERIAL_IN];
    assign red_op_A    = flags_q[F_RED_OP_A];
    assign red_op_B    = flags_q[F_RED_OP_B];
    assign bypass_A    = flags_q[F_BYPASS_A];
    assign bypass_B    = flags_q[F_BYPASS_B];
    assign direction   = flags_q[F_DIRECTION];
    assign issue_valid = (state_q == S_ACTIVE);
    assign reject_cnt  = reject_q;

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Bench for alsu_cmd_issuer: directed tables, multi-cycle corner sequences and
// random traffic against a queue-based reference model.
module tb_alsu_cmd_issuer;
    import alsu_pkg::*;

    localparam int DEPTH = 4;
    localparam int REP_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_opcode = '0;
    logic [2:0] cmd_A = '0;
    logic [2:0] cmd_B = '0;
    logic [6:0] cmd_flags = '0;
    logic [3:0] cmd_repeat = '0;
    logic [2:0] A, B, opcode;
    logic       cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
    logic       issue_valid;
    logic [2:0] fifo_count;
    logic [7:0] reject_cnt;

    always #5 clk = ~clk;

    alsu_cmd_issuer #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_A(cmd_A), .cmd_B(cmd_B),
        .cmd_flags(cmd_flags), .cmd_repeat(cmd_repeat),
        .A(A), .B(B), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction),
        .issue_valid(issue_valid), .fifo_count(fifo_count), .reject_cnt(reject_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending queue plus the currently held command
    typedef struct {
        logic [2:0] op, a, b;
        logic [6:0] fl;
        int         rep;
    } mcmd_t;

    mcmd_t      mq[$];
    mcmd_t      m_cur;
    bit         m_active;
    bit         m_loaded;
    int         m_rem;
    int         m_rej;
    logic [2:0] iss_op[$];
    logic [2:0] iss_a[$];
    logic [2:0] iss_b[$];
    int         iv_run;
    int         iv_best;

    typedef struct {
        logic       v;
        logic [2:0] op, a, b;
        logic [6:0] fl;
        int         rep;
        logic       eiv;
        logic [2:0] eop, ea, eb;
        logic [6:0] efl;
        logic [2:0] ecnt;
        logic       erdy;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] out_flags();
        return {cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction};
    endfunction

    function automatic logic [28:0] act_vec();
        return {issue_valid, opcode, A, B, out_flags(), fifo_count, cmd_ready, reject_cnt};
    endfunction

    function automatic logic [28:0] exp_vec();
        logic [20:0] pins;
        pins = m_active ? {1'b1, m_cur.op, m_cur.a, m_cur.b, m_cur.fl} : 21'd0;
        return {pins[20:0], 3'(mq.size()), (mq.size() != DEPTH), 8'(m_rej)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_loaded = 0;
        m_rem    = 0;
        m_rej    = 0;
        m_cur    = '{op: 0, a: 0, b: 0, fl: 0, rep: 0};
        iss_op.delete();
        iss_a.delete();
        iss_b.delete();
        iv_run  = 0;
        iv_best = 0;
    endtask

    task automatic model_edge();
        bit    rdy, bad, byp;
        mcmd_t c;
        rdy   = (mq.size() != DEPTH);
        c.op  = cmd_opcode;
        c.a   = cmd_A;
        c.b   = cmd_B;
        c.fl  = cmd_flags;
        c.rep = int'(cmd_repeat);
        bad   = (c.op >= 6) || ((c.fl[4] || c.fl[3]) && c.op >= 2);
        byp   = c.fl[2] || c.fl[1];
        m_loaded = 0;
        if (mq.size() > 0 && (!m_active || m_rem == 1)) begin
            m_cur    = mq.pop_front();
            m_rem    = (m_cur.rep == 0) ? 1 : m_cur.rep;
            m_active = 1;
            m_loaded = 1;
        end else if (m_active) begin
            if (m_rem > 1) m_rem--;
            else m_active = 0;
        end
        if (cmd_valid && rdy) begin
            if (bad && !byp) begin
                if (m_rej < 255) m_rej++;
            end else begin
                mq.push_back(c);
            end
        end
    endtask

    task automatic step(string name);
        @(posedge clk);
        model_edge();
        #1;
        if (m_loaded) begin
            iss_op.push_back(opcode);
            iss_a.push_back(A);
            iss_b.push_back(B);
        end
        if (issue_valid) iv_run++;
        else iv_run = 0;
        if (iv_run > iv_best) iv_best = iv_run;
        chk(name, 32'(act_vec()), 32'(exp_vec()));
    endtask

    task automatic drive(logic v, logic [2:0] op, logic [2:0] a, logic [2:0] b,
                         logic [6:0] fl, int rep);
        cmd_valid  = v;
        cmd_opcode = op;
        cmd_A      = a;
        cmd_B      = b;
        cmd_flags  = fl;
        cmd_repeat = 4'(rep);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        model_reset();
        chk("reset_state", 32'(act_vec()), {3'b0, 1'b0, 21'd0, 3'd0, 1'b1, 8'd0});
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic vec_t mkvec(logic v, logic [2:0] op, logic [2:0] a, logic [2:0] b,
                                   logic [6:0] fl, int rep, logic eiv, logic [2:0] eop,
                                   logic [2:0] ea, logic [2:0] eb, logic [6:0] efl,
                                   logic [2:0] ecnt, logic erdy);
        vec_t r;
        r.v = v; r.op = op; r.a = a; r.b = b; r.fl = fl; r.rep = rep;
        r.eiv = eiv; r.eop = eop; r.ea = ea; r.eb = eb; r.efl = efl;
        r.ecnt = ecnt; r.erdy = erdy;
        return r;
    endfunction

    initial begin
        int n;

        // Single ADD (repeat 0 -> one cycle), then SHIFT held for 6 cycles
        tbl[0]  = mkvec(1, OP_ADD,   3, 2, 7'b1000000, 0, 0, 0, 0, 0, 7'b0000000, 1, 1);
        tbl[1]  = mkvec(0, 0,        0, 0, 7'b0000000, 0, 1, 2, 3, 2, 7'b1000000, 0, 1);
        tbl[2]  = mkvec(0, 0,        0, 0, 7'b0000000, 0, 0, 0, 0, 0, 7'b0000000, 0, 1);
        tbl[3]  = mkvec(1, OP_SHIFT, 0, 0, 7'b0100001, 6, 0, 0, 0, 0, 7'b0000000, 1, 1);
        for (int i = 4; i < 10; i++)
            tbl[i] = mkvec(0, 0, 0, 0, 7'b0000000, 0, 1, 4, 0, 0, 7'b0100001, 0, 1);
        tbl[10] = mkvec(0, 0,        0, 0, 7'b0000000, 0, 0, 0, 0, 0, 7'b0000000, 0, 1);
        tbl[11] = mkvec(0, 0,        0, 0, 7'b0000000, 0, 0, 0, 0, 0, 7'b0000000, 0, 1);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].fl, tbl[i].rep);
            step("tbl_model");
            chk($sformatf("tbl_row%0d", i),
                32'({issue_valid, opcode, A, B, out_flags(), fifo_count, cmd_ready}),
                32'({tbl[i].eiv, tbl[i].eop, tbl[i].ea, tbl[i].eb, tbl[i].efl,
                     tbl[i].ecnt, tbl[i].erdy}));
        end

        // Full FIFO behind a 15-cycle hold
        do_reset();
        drive(1, OP_XOR, 1, 0, 0, 15); step("full_push0");
        for (int i = 2; i <= 5; i++) begin
            drive(1, OP_OR, 3'(i), 3'(i), 0, 1);
            step("full_push");
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("full_state", 32'({fifo_count, cmd_ready}), {28'd0, 3'd4, 1'b0});
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step("full_drain");
            n++;
            if (cmd_ready) break;
        end
        chk("ready_rise_edge", 32'(n), 32'd12);
        repeat (6) step("full_tail");
        chk("full_issue_count", 32'(iss_a.size()), 32'd5);
        for (int i = 0; i < iss_a.size(); i++)
            chk($sformatf("full_order%0d", i), 32'(iss_a[i]), 32'(i + 1));

        // Screening: two drops, one bypassed invalid op
        do_reset();
        drive(1, 3'd6,   0, 0,      7'b0000000, 0); step("scr0");
        drive(1, OP_ADD, 1, 1,      7'b0010000, 0); step("scr1");
        drive(1, 3'd7,   0, 3'b110, 7'b0000010, 0); step("scr2");
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step("scr_tail");
        chk("scr_reject_cnt", 32'(reject_cnt), 32'd2);
        chk("scr_issue_count", 32'(iss_b.size()), 32'd1);
        if (iss_b.size() > 0) begin
            chk("scr_issued_B", 32'(iss_b[0]), 32'b110);
            chk("scr_issued_op", 32'(iss_op[0]), 32'd7);
        end
        drive(1, 3'd6, 0, 0, 0, 0);
        repeat (300) step("scr_sat");
        drive(0, 0, 0, 0, 0, 0);
        chk("scr_saturate", 32'(reject_cnt), 32'd255);

        // Back-to-back streaming, pointers wrap twice
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'(i % 6), 3'(i), 3'(7 - i), 0, 1);
            step("b2b_push");
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) step("b2b_tail");
        chk("b2b_run_len", 32'(iv_best), 32'd8);
        chk("b2b_count", 32'(iss_a.size()), 32'd8);
        for (int i = 0; i < iss_a.size(); i++)
            chk($sformatf("b2b_order%0d", i), 32'({iss_a[i], iss_b[i]}), 32'({3'(i), 3'(7 - i)}));

        // Asynchronous reset in the third hold cycle of a repeat-8 command
        do_reset();
        drive(1, OP_ADD, 1, 1, 0, 8); step("rmid0");
        drive(1, OP_OR,  2, 2, 0, 1); step("rmid1");
        drive(1, OP_XOR, 3, 3, 0, 1); step("rmid2");
        drive(0, 0, 0, 0, 0, 0);      step("rmid3");
        chk("rmid_queued", 32'({issue_valid, fifo_count}), {28'd0, 1'b1, 3'd2});
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rmid_async", 32'(act_vec()), {3'b0, 1'b0, 21'd0, 3'd0, 1'b1, 8'd0});
        @(negedge clk);
        rst = 1'b1;
        drive(1, OP_ADD, 3, 1, 0, 2); step("rpost0");
        drive(0, 0, 0, 0, 0, 0);      step("rpost1");
        chk("rpost_issue", 32'({issue_valid, opcode, A, B}), {22'd0, 1'b1, 3'd2, 3'd3, 3'd1});

        // Random traffic against the model
        do_reset();
        repeat (600) begin
            drive(($urandom % 4) != 0, 3'($urandom), 3'($urandom), 3'($urandom),
                  7'($urandom), int'($urandom_range(0, 4)));
            step("rand");
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (30) step("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
